// File: rtl/uart_sys_ctrl_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, operand
// register addresses, FSM state encoding and TX byte selection.
package uart_sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [3:0] OPA_ADDR = 4'd0;
    localparam logic [3:0] OPB_ADDR = 4'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FN,
        ST_ALU_WAIT,
        ST_SEND_RD,
        ST_SEND_LO,
        ST_SEND_HI
    } state_t;

    typedef enum logic [1:0] {
        SEL_RD,
        SEL_LO,
        SEL_HI
    } tx_sel_t;

    // States that are waiting on the next byte of a frame (subject to timeout)
    function automatic logic is_frame_state(state_t s);
        return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
               (s == ST_ALU_A)   || (s == ST_ALU_B)   || (s == ST_ALU_FN);
    endfunction

endpackage

// File: rtl/uart_sys_ctrl_tx_sender.sv
// Response byte holder: keeps the last read byte and ALU result, and pushes
// one selected byte into the TX FIFO per acknowledged request. A request is
// acknowledged only in a cycle where the FIFO reports not-full.
module ctrl_tx_sender
    import uart_sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     send_en,
    input  tx_sel_t                  sel,
    input  logic                     fifo_full,
    input  logic                     load_rd,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     load_alu,
    input  logic [ALU_OUT_WIDTH-1:0] alu_data,
    output logic                     send_ack,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_vld
);

    logic [DATA_WIDTH-1:0]    rd_byte;
    logic [ALU_OUT_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0]    sel_byte;

    assign send_ack = send_en && !fifo_full;

    // Pick the response byte for the current send state
    always_comb begin
        sel_byte = rd_byte;
        case (sel)
            SEL_LO:  sel_byte = alu_res[DATA_WIDTH-1:0];
            SEL_HI:  sel_byte = alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
            default: sel_byte = rd_byte;
        endcase
    end

    // Capture response data and emit a one-cycle FIFO write per acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_byte <= '0;
            alu_res <= '0;
            tx_data <= '0;
            tx_vld  <= 1'b0;
        end else begin
            if (load_rd)  rd_byte <= rd_data;
            if (load_alu) alu_res <= alu_data;
            tx_vld <= send_ack;
            if (send_ack) tx_data <= sel_byte;
        end
    end

endmodule

// File: rtl/uart_sys_ctrl.sv
// Command sequencer behind the UART receiver. Parses command frames from
// received bytes, drives register-file writes/reads and ALU operations, and
// queues response bytes to the TX FIFO. Every output is registered.
// Optional build macro CTRL_TIMEOUT_EN: abort a stalled frame to IDLE after
// TIMEOUT_CYCLES cycles without a byte.
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | waiting for an opcode byte, others dropped
// WR_ADDR     | write frame, waiting for address byte
// WR_DATA     | write frame, waiting for data byte
// RD_ADDR     | read frame, waiting for address byte
// RD_WAIT     | read strobe issued, waiting for RF read data
// ALU_A       | ALU frame, waiting for operand A (stored at RF 0)
// ALU_B       | ALU frame, waiting for operand B (stored at RF 1)
// ALU_FN      | waiting for ALU function byte
// ALU_WAIT    | ALU enabled, waiting for result
// SEND_RD     | sending read byte to TX FIFO
// SEND_LO     | sending ALU result low byte
// SEND_HI     | sending ALU result high byte
module uart_sys_ctrl
    import uart_sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 2047
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]    RF_Address,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wdata_nxt;
    logic [3:0]              fun_nxt;
    logic                    wr_en_nxt, rd_en_nxt, alu_en_nxt, gate_nxt;
    logic                    load_rd, load_alu, send_en, send_ack, timeout;
    tx_sel_t                 sel;

`ifdef CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Down-counter reloaded on state change and on every byte; zero means stalled
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                               to_cnt <= TO_W'(TIMEOUT_CYCLES);
        else if (state_nxt != state || RX_D_VLD) to_cnt <= TO_W'(TIMEOUT_CYCLES);
        else if (to_cnt != '0)                  to_cnt <= to_cnt - TO_W'(1);
    end

    assign timeout = is_frame_state(state) && (to_cnt == '0) && !RX_D_VLD;
`else
    assign timeout = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_nxt  = state;
        addr_nxt   = RF_Address;
        wdata_nxt  = RF_WrData;
        fun_nxt    = ALU_FUN;
        wr_en_nxt  = 1'b0;
        rd_en_nxt  = 1'b0;
        alu_en_nxt = 1'b0;
        load_rd    = 1'b0;
        load_alu   = 1'b0;
        send_en    = 1'b0;
        sel        = SEL_RD;
        case (state)
            ST_IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_RF_WR:   state_nxt = ST_WR_ADDR;
                    CMD_RF_RD:   state_nxt = ST_RD_ADDR;
                    CMD_ALU_OP:  state_nxt = ST_ALU_A;
                    CMD_ALU_NOP: state_nxt = ST_ALU_FN;
                    default:     state_nxt = ST_IDLE;
                endcase
            end
            ST_WR_ADDR: if (RX_D_VLD) begin
                addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_nxt = ST_WR_DATA;
            end
            ST_WR_DATA: if (RX_D_VLD) begin
                wr_en_nxt = 1'b1;
                wdata_nxt = RX_P_DATA;
                state_nxt = ST_IDLE;
            end
            ST_RD_ADDR: if (RX_D_VLD) begin
                rd_en_nxt = 1'b1;
                addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (RF_RdData_VLD) begin
                load_rd   = 1'b1;
                state_nxt = ST_SEND_RD;
            end
            ST_ALU_A: if (RX_D_VLD) begin
                wr_en_nxt = 1'b1;
                addr_nxt  = ADDR_WIDTH'(OPA_ADDR);
                wdata_nxt = RX_P_DATA;
                state_nxt = ST_ALU_B;
            end
            ST_ALU_B: if (RX_D_VLD) begin
                wr_en_nxt = 1'b1;
                addr_nxt  = ADDR_WIDTH'(OPB_ADDR);
                wdata_nxt = RX_P_DATA;
                state_nxt = ST_ALU_FN;
            end
            ST_ALU_FN: if (RX_D_VLD) begin
                alu_en_nxt = 1'b1;
                fun_nxt    = RX_P_DATA[3:0];
                state_nxt  = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    load_alu  = 1'b1;
                    state_nxt = ST_SEND_LO;
                end else begin
                    alu_en_nxt = 1'b1;
                end
            end
            ST_SEND_RD: begin
                send_en = 1'b1;
                sel     = SEL_RD;
                if (send_ack) state_nxt = ST_IDLE;
            end
            ST_SEND_LO: begin
                send_en = 1'b1;
                sel     = SEL_LO;
                if (send_ack) state_nxt = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                send_en = 1'b1;
                sel     = SEL_HI;
                if (send_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (timeout) state_nxt = ST_IDLE;
        gate_nxt = (state_nxt == ST_ALU_FN) || (state_nxt == ST_ALU_WAIT);
    end

    // State and registered control outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
        end else begin
            state       <= state_nxt;
            RF_Address  <= addr_nxt;
            RF_WrData   <= wdata_nxt;
            RF_WrEn     <= wr_en_nxt;
            RF_RdEn     <= rd_en_nxt;
            ALU_EN      <= alu_en_nxt;
            ALU_FUN     <= fun_nxt;
            CLK_GATE_EN <= gate_nxt;
        end
    end

    ctrl_tx_sender #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ALU_OUT_WIDTH(ALU_OUT_WIDTH)
    ) u_tx_sender (
        .clk      (CLK),
        .rst_n    (RST),
        .send_en  (send_en),
        .sel      (sel),
        .fifo_full(FIFO_FULL),
        .load_rd  (load_rd),
        .rd_data  (RF_RdData),
        .load_alu (load_alu),
        .alu_data (ALU_OUT),
        .send_ack (send_ack),
        .tx_data  (TX_P_DATA),
        .tx_vld   (TX_D_VLD)
    );

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Directed bench for uart_sys_ctrl: frames are driven byte by byte, strobes
// are logged by a monitor and compared against hand-computed expectations.
module tb_uart_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RF_RdData = '0;
    logic        RF_RdData_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [3:0]  RF_Address;
    logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    logic [7:0]  RF_WrData, TX_P_DATA;
    logic [3:0]  ALU_FUN;

    uart_sys_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .FIFO_FULL(FIFO_FULL),
        .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor, sampled just after each rising edge
    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    int excl_err = 0;
    int full_err = 0;

    always begin
        @(posedge CLK);
        #1;
        if (RF_WrEn)  wr_q.push_back({RF_Address, RF_WrData});
        if (RF_RdEn)  rd_q.push_back(RF_Address);
        if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
        if ((int'(RF_WrEn) + int'(RF_RdEn) + int'(TX_D_VLD)) > 1) excl_err++;
        if (TX_D_VLD && FIFO_FULL) full_err++;
    end

    function automatic logic [31:0] wr_at(int i);
        return (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] rd_at(int i);
        return (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] tx_at(int i);
        return (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic alu_result(input logic [15:0] r);
        ALU_OUT     = r;
        ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
    endtask

    int wb, rb, tb;

    initial begin
        cyc(3);
        chk("rst_wren",  32'(RF_WrEn), 0);
        chk("rst_rden",  32'(RF_RdEn), 0);
        chk("rst_txvld", 32'(TX_D_VLD), 0);
        chk("rst_aluen", 32'(ALU_EN), 0);
        chk("rst_gate",  32'(CLK_GATE_EN), 0);
        chk("rst_addr",  32'(RF_Address), 0);
        RST = 1'b1;
        cyc(2);

        // Write frame
        wb = wr_q.size(); tb = tx_q.size();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        cyc(4);
        chk("wr_count", 32'(wr_q.size() - wb), 1);
        chk("wr_entry", wr_at(wb), 32'h53C);
        chk("wr_no_tx", 32'(tx_q.size() - tb), 0);

        // Read frame, RF answers one cycle after the read strobe
        rb = rd_q.size(); tb = tx_q.size();
        send_byte(8'hBB); send_byte(8'h05);
        chk("rd_strobe", 32'(RF_RdEn), 1);
        RF_RdData = 8'h3C; RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        cyc(5);
        chk("rd_count", 32'(rd_q.size() - rb), 1);
        chk("rd_addr",  rd_at(rb), 5);
        chk("rd_tx_n",  32'(tx_q.size() - tb), 1);
        chk("rd_tx_b",  tx_at(tb), 32'h3C);

        // ALU frame with operands
        wb = wr_q.size(); tb = tx_q.size();
        send_byte(8'hCC);
        chk("op_gate_a", 32'(CLK_GATE_EN), 0);
        send_byte(8'h0A); send_byte(8'h03);
        chk("op_gate_fn", 32'(CLK_GATE_EN), 1);
        send_byte(8'h00);
        chk("op_aluen",  32'(ALU_EN), 1);
        chk("op_fun",    32'(ALU_FUN), 0);
        cyc(3);
        chk("op_hold",   32'(ALU_EN), 1);
        chk("op_gate_w", 32'(CLK_GATE_EN), 1);
        alu_result(16'h000D);
        chk("op_aluen_off", 32'(ALU_EN), 0);
        chk("op_gate_off",  32'(CLK_GATE_EN), 0);
        cyc(5);
        chk("op_wr_n",  32'(wr_q.size() - wb), 2);
        chk("op_wr_a",  wr_at(wb), 32'h00A);
        chk("op_wr_b",  wr_at(wb + 1), 32'h103);
        chk("op_tx_n",  32'(tx_q.size() - tb), 2);
        chk("op_tx_lo", tx_at(tb), 32'h0D);
        chk("op_tx_hi", tx_at(tb + 1), 32'h00);

        // ALU frame without operands, FIFO full for 20 cycles after result
        wb = wr_q.size(); tb = tx_q.size();
        send_byte(8'hDD); send_byte(8'h02);
        chk("nop_fun", 32'(ALU_FUN), 2);
        FIFO_FULL = 1'b1;
        alu_result(16'hA55A);
        cyc(19);
        chk("full_no_tx", 32'(tx_q.size() - tb), 0);
        FIFO_FULL = 1'b0;
        cyc(6);
        chk("full_tx_n",  32'(tx_q.size() - tb), 2);
        chk("full_tx_lo", tx_at(tb), 32'h5A);
        chk("full_tx_hi", tx_at(tb + 1), 32'hA5);
        chk("nop_no_wr",  32'(wr_q.size() - wb), 0);

        // Junk byte and stray valid pulses in IDLE, byte during ALU_WAIT
        wb = wr_q.size(); rb = rd_q.size(); tb = tx_q.size();
        send_byte(8'h55);
        RF_RdData_VLD = 1'b1; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
        cyc(4);
        chk("junk_tx",    32'(tx_q.size() - tb), 0);
        chk("junk_aluen", 32'(ALU_EN), 0);
        send_byte(8'hDD); send_byte(8'h03);
        send_byte(8'hAA);
        cyc(2);
        chk("drop_aluen", 32'(ALU_EN), 1);
        alu_result(16'h0107);
        cyc(6);
        send_byte(8'h05); send_byte(8'h3C);
        cyc(4);
        chk("drop_tx_n",  32'(tx_q.size() - tb), 2);
        chk("drop_tx_lo", tx_at(tb), 32'h07);
        chk("drop_tx_hi", tx_at(tb + 1), 32'h01);
        chk("drop_no_wr", 32'(wr_q.size() - wb), 0);
        chk("drop_no_rd", 32'(rd_q.size() - rb), 0);

        // Reset in the middle of a write frame
        wb = wr_q.size();
        send_byte(8'hAA); send_byte(8'h05);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_addr", 32'(RF_Address), 0);
        chk("mid_rst_wren", 32'(RF_WrEn), 0);
        RST = 1'b1;
        send_byte(8'h3C);
        cyc(4);
        chk("mid_rst_no_wr", 32'(wr_q.size() - wb), 0);
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
        cyc(3);
        chk("post_rst_wr", wr_at(wb), 32'h799);

`ifdef CTRL_TIMEOUT_EN
        // Stall beyond the limit aborts the frame; a short stall does not
        wb = wr_q.size();
        send_byte(8'hAA);
        cyc(2100);
        send_byte(8'h05); send_byte(8'h3C);
        cyc(4);
        chk("to_no_wr", 32'(wr_q.size() - wb), 0);
        send_byte(8'hAA);
        cyc(100);
        send_byte(8'h06); send_byte(8'h42);
        cyc(4);
        chk("to_short_wr", wr_at(wb), 32'h642);
`endif

        chk("one_hot_strobes", 32'(excl_err), 0);
        chk("tx_while_full",   32'(full_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
